// File: rtl/gpu_dram_req_queue.sv
// gpu_dram_req_queue
//
// Request buffer between the GPU core's DRAM port and a single-beat AXI4
// master FSM. Core requests are queued in order in a FIFO. Exactly one
// transaction is outstanding on the memory side at a time. Read data goes
// back to the core over a held response handshake. Write completions are
// absorbed here and never reach the core.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clk edge where valid && ready are both high. Once the producer raises
// valid, it holds valid and its payload stable until that edge. The
// consumer may drive ready independently of valid.
//
// Ports
//   clk, rst           core clock; asynchronous active-high reset
//   i_req_*/o_req_ready core request channel (we, addr, wdata)
//   o_rsp_*/i_rsp_ready read response channel (rdata, err)
//   o_mem_*/i_mem_ready transaction to the AXI master (we, addr, wdata)
//   i_mem_done         1-cycle completion pulse, with i_mem_rdata/i_mem_resp
//   o_level            FIFO occupancy (excludes the in-flight transaction)
//   o_err_cnt          saturating count of non-OKAY completions
//   o_busy             FIFO non-empty or FSM not idle
//   o_state            FSM state, exposed for debug and checkers
module gpu_dram_req_queue #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [ADDR_WIDTH-1:0]    i_req_addr,
    input  logic [DATA_WIDTH-1:0]    i_req_wdata,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [DATA_WIDTH-1:0]    o_rsp_rdata,
    output logic                     o_rsp_err,
    output logic                     o_mem_valid,
    input  logic                     i_mem_ready,
    output logic                     o_mem_we,
    output logic [ADDR_WIDTH-1:0]    o_mem_addr,
    output logic [DATA_WIDTH-1:0]    o_mem_wdata,
    input  logic                     i_mem_done,
    input  logic [DATA_WIDTH-1:0]    i_mem_rdata,
    input  logic [1:0]               i_mem_resp,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
    output logic                     o_busy,
    output logic [1:0]               o_state
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // ---------------------------------------------------------------
    // Request FIFO
    // ---------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     level_q, level_d;
    logic               full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Ready comes from registered occupancy only. A pop in the same cycle
    // does not open a slot for a push while full.
    assign full = (level_q == LEVEL_FULL);
    assign push = i_req_valid && !full;
    assign head = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {i_req_we, i_req_addr, i_req_wdata};
        end
    end

    // ---------------------------------------------------------------
    // Issue / response FSM
    // ---------------------------------------------------------------
    logic [1:0]               state_q, state_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    // The head is popped only from IDLE, which keeps one transaction in
    // flight and preserves read-after-write ordering to the same address.
    assign pop = (state_q == ST_IDLE) && (level_q != '0);

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    {mem_we_d, mem_addr_d, mem_wdata_d} = head;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Completions are only meaningful here; a stray pulse in
                // any other state is dropped.
                if (i_mem_done) begin
                    if ((i_mem_resp != 2'b00) && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_rdata_d = i_mem_rdata;
                        rsp_err_d   = (i_mem_resp != 2'b00);
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign o_req_ready = !full;
    assign o_mem_valid = (state_q == ST_ISSUE);
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_level     = level_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_busy      = (state_q != ST_IDLE) || (level_q != '0);
    assign o_state     = state_q;

endmodule
